adder_share_arbiter: RTL

//  Shares one combinational 32-bit prefix adder (parallel-prefix main) among N_REQ requesters.

---
 rtl/adder_share_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among N_REQ requesters.
// One operation in flight: operands registered onto the adder, result captured a cycle later.
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_s,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic [ID_W:0]     pos;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              accept;
  logic [N_REQ-1:0]  ready_comb;

  logic [WIDTH-1:0]  add_a_reg, add_b_reg, rsp_sum_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_cout_reg;

  // Search starting at rr_ptr, wrapping modulo N_REQ (works for non-power-of-two N_REQ).
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    pos         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(N_REQ)) begin
        pos = pos - (ID_W+1)'(N_REQ);
      end
      if (!grant_found && req_valid[pos[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = pos[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    ready_comb  = '0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          ready_comb  = N_REQ'(1) << grant_id;
          accept      = 1'b1;
          state_next  = EXEC;
          rr_ptr_next = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      add_a_reg    <= '0;
      add_b_reg    <= '0;
      rsp_id_reg   <= '0;
      rsp_sum_reg  <= '0;
      rsp_cout_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (accept) begin
        add_a_reg  <= sel_a;
        add_b_reg  <= sel_b;
        rsp_id_reg <= grant_id;
      end
      // Adder inputs have been stable for a full cycle by the end of EXEC.
      if (state_reg == EXEC) begin
        rsp_sum_reg  <= add_s;
        rsp_cout_reg <= add_cout;
      end
    end
  end

  assign req_ready = rst_n ? ready_comb : '0;
  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);

endmodule
